// File: rtl/trigger_sequencer_if.sv
// Control/status bundle between the trigger sequencer and its host.
// master drives arm/abort/trigger/config; slave is the sequencer itself.
interface trigger_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             arm;
  logic             abort;
  logic             trigger_in;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_length;
  logic             armed;
  logic             busy;
  logic             capture_start;
  logic             capture_en;
  logic             done;
  logic [7:0]       trig_count;
  logic             auto_trig;

  modport master (
    output arm, abort, trigger_in, cfg_delay, cfg_length,
    input  armed, busy, capture_start, capture_en, done, trig_count, auto_trig
  );

  modport slave (
    input  arm, abort, trigger_in, cfg_delay, cfg_length,
    output armed, busy, capture_start, capture_en, done, trig_count, auto_trig
  );
endinterface

// File: rtl/trigger_sequencer.sv
// One capture cycle per arm: trigger edge -> delay -> capture window -> holdoff -> idle.
// Optional timeout auto-trigger in ARMED when TRIGGER_SEQUENCER_AUTO_TRIGGER_EN is defined.
module trigger_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned HOLDOFF = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic               clk,
  input logic               reset,
  trigger_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StDelay,
    StCapture,
    StHoldoff
  } state_e;

  // Holdoff always lasts at least one cycle (the done cycle).
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'((HOLDOFF > 1) ? HOLDOFF - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] len_last_q, len_last_d;
  logic             trig_q;
  logic             trig_edge;
  logic             timeout_hit;
  logic             armed_q, armed_d;
  logic             busy_q, busy_d;
  logic             capture_start_q, capture_start_d;
  logic             capture_en_q, capture_en_d;
  logic             done_q, done_d;
  logic [7:0]       trig_count_q, trig_count_d;

  assign trig_edge = bus.trigger_in & ~trig_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    delay_d         = delay_q;
    len_last_d      = len_last_q;
    trig_count_d    = trig_count_q;
    capture_start_d = 1'b0;
    done_d          = 1'b0;

    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.arm) begin
            state_d    = StArmed;
            delay_d    = bus.cfg_delay;
            // Store L-1 so the window check is a plain equality; L=0 behaves as L=1.
            len_last_d = (bus.cfg_length == '0) ? '0 : bus.cfg_length - 1'b1;
          end
        end
        StArmed: begin
          if (trig_edge || timeout_hit) begin
            state_d      = StDelay;
            cnt_d        = '0;
            trig_count_d = trig_count_q + 8'd1;
          end
        end
        StDelay: begin
          if (cnt_q == delay_q) begin
            state_d         = StCapture;
            cnt_d           = '0;
            capture_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCapture: begin
          if (cnt_q == len_last_q) begin
            state_d = StHoldoff;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHoldoff: begin
          if (cnt_q == HoldLast) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    armed_d      = (state_d == StArmed);
    busy_d       = (state_d != StIdle);
    capture_en_d = (state_d == StCapture);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      delay_q         <= '0;
      len_last_q      <= '0;
      trig_q          <= 1'b0;
      armed_q         <= 1'b0;
      busy_q          <= 1'b0;
      capture_start_q <= 1'b0;
      capture_en_q    <= 1'b0;
      done_q          <= 1'b0;
      trig_count_q    <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      delay_q         <= delay_d;
      len_last_q      <= len_last_d;
      trig_q          <= bus.trigger_in;
      armed_q         <= armed_d;
      busy_q          <= busy_d;
      capture_start_q <= capture_start_d;
      capture_en_q    <= capture_en_d;
      done_q          <= done_d;
      trig_count_q    <= trig_count_d;
    end
  end

`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
  localparam int unsigned ToEff  = (TIMEOUT > 0) ? TIMEOUT : 1;
  localparam int unsigned ToW    = (ToEff > 1) ? $clog2(ToEff) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(ToEff - 1);

  logic [ToW-1:0] to_q, to_d;
  logic           auto_trig_q, auto_trig_d;

  assign timeout_hit = (state_q == StArmed) && (to_q == ToLast);

  always_comb begin
    to_d        = '0;
    auto_trig_d = auto_trig_q;
    if (state_q == StArmed && state_d == StArmed) begin
      to_d = to_q + 1'b1;
    end
    if (!bus.abort) begin
      if (state_q == StIdle && bus.arm) begin
        auto_trig_d = 1'b0;
      end else if (timeout_hit && !trig_edge) begin
        auto_trig_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_q        <= '0;
      auto_trig_q <= 1'b0;
    end else begin
      to_q        <= to_d;
      auto_trig_q <= auto_trig_d;
    end
  end

  assign bus.auto_trig = auto_trig_q;
`else
  assign timeout_hit   = 1'b0;
  assign bus.auto_trig = 1'b0;
`endif

  assign bus.armed         = armed_q;
  assign bus.busy          = busy_q;
  assign bus.capture_start = capture_start_q;
  assign bus.capture_en    = capture_en_q;
  assign bus.done          = done_q;
  assign bus.trig_count    = trig_count_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer with a capture-window scoreboard.
module tb_trigger_sequencer;

`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
  localparam int unsigned TbTimeout = 20;
`else
  localparam int unsigned TbTimeout = 1000;
`endif

  typedef struct {
    int         start;
    int         len;
    logic [7:0] cnt;
    logic       auto_f;
    logic       done_f;
  } exp_t;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;
  int   cyc;
  int   k;
  int   s;
  int   a;
  int   run;
  bit   in_cap;
  exp_t sb[$];
  exp_t cur;

  trigger_sequencer_if #(.CNT_W(16)) bus ();

  trigger_sequencer #(
    .CNT_W  (16),
    .HOLDOFF(8),
    .TIMEOUT(TbTimeout)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Advance one clock; sample outputs 1 time unit after the edge and run the scoreboard.
  task automatic tick();
    bit ended;
    @(posedge clk);
    cyc++;
    #1;
    ended = 1'b0;
    if (bus.capture_start) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $error("FAIL unexpected_capture: observed start at %0d expected none", cyc);
      end else begin
        cur    = sb.pop_front();
        in_cap = 1'b1;
        run    = 0;
        check("cap_start_cycle", cyc, cur.start);
        check("cap_start_en", {31'd0, bus.capture_en}, 1);
        check("cap_trig_count", {24'd0, bus.trig_count}, {24'd0, cur.cnt});
        check("cap_auto_trig", {31'd0, bus.auto_trig}, {31'd0, cur.auto_f});
      end
    end
    if (in_cap) begin
      if (bus.capture_en) begin
        run++;
      end else begin
        in_cap = 1'b0;
        ended  = 1'b1;
        check("cap_len", run, cur.len);
        check("cap_done", {31'd0, bus.done}, {31'd0, cur.done_f});
      end
    end
    if (bus.done && !ended) check("spurious_done", {31'd0, bus.done}, 0);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && bus.busy; i++) tick();
    check("idle_reached", {31'd0, bus.busy}, 0);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 2000 && cyc < target; i++) tick();
    check("cycle_reached", cyc, target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_armed"}, {31'd0, bus.armed}, 0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 0);
    check({tag, "_cap_start"}, {31'd0, bus.capture_start}, 0);
    check({tag, "_cap_en"}, {31'd0, bus.capture_en}, 0);
    check({tag, "_done"}, {31'd0, bus.done}, 0);
    check({tag, "_trig_count"}, {24'd0, bus.trig_count}, 0);
    check({tag, "_auto_trig"}, {31'd0, bus.auto_trig}, 0);
  endtask

  initial begin
    vecs           = 0;
    errs           = 0;
    cyc            = 0;
    in_cap         = 1'b0;
    run            = 0;
    reset          = 1'b1;
    bus.arm        = 1'b0;
    bus.abort      = 1'b0;
    bus.trigger_in = 1'b0;
    bus.cfg_delay  = '0;
    bus.cfg_length = '0;

    // Reset state
    #2;
    check_all_zero("reset");
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // D=3, L=4: start k+4, window 4 cycles, done k+8, idle k+16
    bus.cfg_delay  = 16'd3;
    bus.cfg_length = 16'd4;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    check("s1_armed", {31'd0, bus.armed}, 1);
    check("s1_busy", {31'd0, bus.busy}, 1);
    tick();
    tick();
    bus.trigger_in = 1'b1;
    k = cyc + 1;
    sb.push_back('{k + 4, 4, 8'd1, 1'b0, 1'b1});
    tick();
    bus.trigger_in = 1'b0;
    check("s1_armed_left", {31'd0, bus.armed}, 0);
    check("s1_trig_count", {24'd0, bus.trig_count}, 1);
    wait_idle(100);
    check("s1_idle_cycle", cyc, k + 16);
    check("s1_sb_empty", sb.size(), 0);

    // D=0, L=0: one-cycle window at k+1, done k+2, idle k+10
    bus.cfg_delay  = 16'd0;
    bus.cfg_length = 16'd0;
    bus.arm        = 1'b1;
    tick();
    bus.arm        = 1'b0;
    bus.trigger_in = 1'b1;
    k = cyc + 1;
    sb.push_back('{k + 1, 1, 8'd2, 1'b0, 1'b1});
    tick();
    bus.trigger_in = 1'b0;
    wait_idle(100);
    check("s2_idle_cycle", cyc, k + 10);

    // Level held through arm, arm in DELAY, edge in CAPTURE, arm in HOLDOFF
    bus.cfg_delay  = 16'd5;
    bus.cfg_length = 16'd3;
    bus.trigger_in = 1'b1;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (3) tick();
    check("s3_held_armed", {31'd0, bus.armed}, 1);
    check("s3_held_count", {24'd0, bus.trig_count}, 2);
    bus.trigger_in = 1'b0;
    tick();
    bus.trigger_in = 1'b1;
    k = cyc + 1;
    sb.push_back('{k + 6, 3, 8'd3, 1'b0, 1'b1});
    tick();
    check("s3_armed_left", {31'd0, bus.armed}, 0);
    bus.arm = 1'b1;
    tick();
    bus.arm        = 1'b0;
    bus.trigger_in = 1'b0;
    check("s3_arm_in_delay", {31'd0, bus.armed}, 0);
    for (int i = 0; i < 50 && !bus.capture_en; i++) tick();
    bus.trigger_in = 1'b1;
    tick();
    bus.trigger_in = 1'b0;
    for (int i = 0; i < 50 && bus.capture_en; i++) tick();
    tick();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    wait_idle(100);
    tick();
    check("s3_arm_in_holdoff", {31'd0, bus.armed}, 0);
    check("s3_trig_count", {24'd0, bus.trig_count}, 3);
    check("s3_sb_empty", sb.size(), 0);

    // Abort in 2nd capture cycle, then immediate re-arm
    bus.cfg_delay  = 16'd2;
    bus.cfg_length = 16'd10;
    bus.arm        = 1'b1;
    tick();
    bus.arm        = 1'b0;
    bus.trigger_in = 1'b1;
    k = cyc + 1;
    s = k + 3;
    sb.push_back('{s, 2, 8'd4, 1'b0, 1'b0});
    tick();
    bus.trigger_in = 1'b0;
    wait_cyc(s + 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("s4_abort_cap_en", {31'd0, bus.capture_en}, 0);
    check("s4_abort_busy", {31'd0, bus.busy}, 0);
    check("s4_abort_count", {24'd0, bus.trig_count}, 4);

    // Re-arm right after abort; changing cfg_delay in ARMED has no effect
    bus.cfg_delay  = 16'd3;
    bus.cfg_length = 16'd2;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    check("s5_rearm", {31'd0, bus.armed}, 1);
    bus.cfg_delay = 16'd50;
    tick();
    bus.trigger_in = 1'b1;
    k = cyc + 1;
    sb.push_back('{k + 4, 2, 8'd5, 1'b0, 1'b1});
    tick();
    bus.trigger_in = 1'b0;
    wait_idle(200);
    check("s5_idle_cycle", cyc, k + 14);

    // Async reset mid-DELAY clears outputs without a clock edge
    bus.cfg_delay  = 16'd20;
    bus.cfg_length = 16'd2;
    bus.arm        = 1'b1;
    tick();
    bus.arm        = 1'b0;
    bus.trigger_in = 1'b1;
    sb.push_back('{cyc + 22, 2, 8'd6, 1'b0, 1'b1});
    tick();
    bus.trigger_in = 1'b0;
    repeat (3) tick();
    check("s6_pre_reset_busy", {31'd0, bus.busy}, 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("s6_async");
    sb.delete();
    #2;
    reset = 1'b0;
    tick();

`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
    // Timeout fires on ARMED cycle 20; start = entry + 20 + 1 + D
    bus.cfg_delay  = 16'd2;
    bus.cfg_length = 16'd3;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    a = cyc;
    check("s7_auto_cleared", {31'd0, bus.auto_trig}, 0);
    sb.push_back('{a + 23, 3, 8'd1, 1'b1, 1'b1});
    wait_idle(200);
    check("s7_auto_set", {31'd0, bus.auto_trig}, 1);
    check("s7_trig_count", {24'd0, bus.trig_count}, 1);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check("s7_auto_rearm_clear", {31'd0, bus.auto_trig}, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("s7_abort_idle", {31'd0, bus.busy}, 0);
`else
    // No timeout: ARMED persists indefinitely
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (1005) tick();
    check("s7_still_armed", {31'd0, bus.armed}, 1);
    check("s7_auto_off", {31'd0, bus.auto_trig}, 0);
    check("s7_count_kept", {24'd0, bus.trig_count}, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("s7_abort_idle", {31'd0, bus.busy}, 0);
`endif
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
